// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte scheduler in front of a shared UART transmitter
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int BAUD_DIV      = 16,
  parameter int TIMEOUT_BAUDS = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_mask,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       timeout_err,
  output logic                       tx_baud,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [15:0]                frame_count
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(BAUD_DIV);
  localparam int WW  = $clog2(TIMEOUT_BAUDS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [BW-1:0]      baud_cnt;
  logic [WW-1:0]      wdog;
  logic [IDW-1:0]     last;
  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     cand;
  logic [7:0]         win_data;

  // Baud generator runs regardless of arbitration state.
  always_ff @(posedge clock) begin
    if (reset || baud_cnt == BW'(BAUD_DIV - 1))
      baud_cnt <= '0;
    else
      baud_cnt <= baud_cnt + 1'b1;
  end

  assign tx_baud = (baud_cnt == BW'(BAUD_DIV - 1));
  assign busy    = (state != S_IDLE);

  // Search starts just after the last successful winner.
  always_comb begin
    elig     = req & ~req_mask;
    found    = 1'b0;
    win      = '0;
    cand     = '0;
    win_data = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last) + k) % NUM_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == win)
        win_data = req_data[8*i +: 8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      ack         <= '0;
      timeout_err <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      frame_count <= '0;
      wdog        <= '0;
      last        <= IDW'(NUM_REQ - 1);
    end else begin
      ack         <= '0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          wdog <= '0;
          if (found) begin
            grant_id <= win;
            tx_data  <= win_data;
            tx_start <= 1'b1;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          // Completion wins over a watchdog expiry in the same cycle.
          if (tx_done) begin
            tx_start    <= 1'b0;
            ack         <= NUM_REQ'(1) << grant_id;
            frame_count <= frame_count + 16'd1;
            last        <= grant_id;
            state       <= S_DONE;
          end else if (tx_baud) begin
            if (wdog == WW'(TIMEOUT_BAUDS - 1)) begin
              tx_start    <= 1'b0;
              timeout_err <= 1'b1;
              state       <= S_DONE;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int BD = 4;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req, req_mask, ack;
  logic [31:0] req_data;
  logic        timeout_err, tx_baud, tx_start, tx_done, busy;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic [15:0] frame_count;

  int          checks = 0;
  int          errors = 0;
  int          model_last;
  logic [15:0] model_fc;

  uart_tx_arbiter #(.NUM_REQ(N), .BAUD_DIV(BD), .TIMEOUT_BAUDS(TO)) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data), .req_mask(req_mask),
    .ack(ack), .timeout_err(timeout_err), .tx_baud(tx_baud), .tx_start(tx_start),
    .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .grant_id(grant_id),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Round-robin rule: first eligible index after the last winner, ascending, wrapping.
  function automatic int pick(input logic [3:0] elig, input int last);
    for (int k = 1; k <= N; k++)
      if (elig[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_last = N - 1;
    model_fc   = 16'd0;
  endtask

  // Called on a negedge while the DUT is idle; done_tick=0 means the transmitter never finishes.
  task automatic do_frame(input int done_tick, input logic [3:0] late);
    int          exp_id;
    logic [7:0]  exp_data;
    logic [31:0] saved;
    int          ticks, guard;
    bit          ok, fin, timed;
    exp_id   = pick(req & ~req_mask, model_last);
    saved    = req_data;
    exp_data = (exp_id < 0) ? 8'h00 : 8'((saved >> (8 * exp_id)) & 32'hFF);
    @(negedge clock);
    check("grant_latency", tx_start, 1'b1);
    check("grant_id", grant_id, 32'(exp_id));
    check("tx_data", tx_data, exp_data);
    check("busy_send", busy, 1'b1);
    req_data = $urandom;
    req      = req | late;
    ticks = 0; guard = 0; ok = 1'b1; fin = 1'b0;
    while (!fin && guard < 500) begin
      if (tx_start !== 1'b1 || tx_data !== exp_data || grant_id !== 2'(exp_id) ||
          ack !== 4'b0 || timeout_err !== 1'b0) ok = 1'b0;
      if (tx_baud) begin
        ticks++;
        if (done_tick != 0 && ticks == done_tick) begin
          tx_done = 1'b1;
          fin     = 1'b1;
        end else if (ticks == TO) begin
          fin = 1'b1;
        end
      end
      @(negedge clock);
      guard++;
    end
    tx_done = 1'b0;
    check("frame_bounded", fin, 1'b1);
    check("hold_stable", ok, 1'b1);
    timed = (done_tick == 0);
    if (!timed) begin
      model_fc   = model_fc + 16'd1;
      model_last = exp_id;
    end
    check("ack", ack, timed ? 32'd0 : (32'd1 << exp_id));
    check("timeout_err", timeout_err, timed);
    check("start_low", tx_start, 1'b0);
    check("busy_done", busy, 1'b1);
    check("frame_count", frame_count, model_fc);
    @(negedge clock);
    check("idle_again", busy, 1'b0);
    check("ack_pulse", ack, 4'b0);
    req_data = saved;
  endtask

  initial begin
    reset = 1'b1; req = '0; req_mask = '0; req_data = '0; tx_done = 1'b0;
    do_reset();
    check("rst_ack", ack, 4'b0);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_id, 2'd0);
    check("rst_fc", frame_count, 16'd0);
    check("rst_tout", timeout_err, 1'b0);
    check("rst_baud", tx_baud, 1'b0);

    // Stray tx_done while idle must be ignored.
    tx_done = 1'b1;
    @(negedge clock);
    tx_done = 1'b0;
    @(negedge clock);
    check("idle_done_ack", ack, 4'b0);
    check("idle_done_fc", frame_count, model_fc);

    // Single requester.
    req = 4'b0100; req_data = 32'h00A5_0000;
    do_frame(11, 4'b0);
    req = '0;

    // Fairness with everyone requesting.
    do_reset();
    req = 4'b1111; req_data = 32'h1312_1110;
    for (int f = 0; f < 5; f++) do_frame(11, 4'b0);
    check("fair_last", 32'(model_last), 32'd0);
    req = '0;

    // Mask, then unmask, with a late arrival during a frame.
    do_reset();
    req = 4'b0011; req_mask = 4'b0001; req_data = $urandom;
    do_frame(11, 4'b0);
    check("mask_served1", 32'(model_last), 32'd1);
    req_mask = '0;
    do_frame(12, 4'b1000);
    check("unmask_served0", 32'(model_last), 32'd0);
    do_frame(11, 4'b0);
    do_frame(11, 4'b0);
    req = '0;

    // Watchdog expiry, regrant of the same requester, then coincident done/timeout.
    do_reset();
    req = 4'b0010; req_data = 32'h0000_5A00;
    do_frame(0, 4'b0);
    do_frame(TO, 4'b0);
    req = '0;

    // Reset in the middle of a frame.
    req = 4'b0100;
    @(negedge clock);
    repeat (5) @(negedge clock);
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_last = N - 1;
    model_fc   = 16'd0;
    check("mrst_tx_start", tx_start, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_grant", grant_id, 2'd0);
    check("mrst_fc", frame_count, 16'd0);
    check("mrst_ack", ack, 4'b0);
    check("mrst_baud", tx_baud, 1'b0);
    req = 4'b1111;
    do_frame(11, 4'b0);
    check("mrst_first0", 32'(model_last), 32'd0);
    req = '0;

    // Randomized traffic.
    for (int f = 0; f < 40; f++) begin
      int r;
      req = 4'($urandom); req_mask = 4'($urandom); req_data = $urandom;
      if ((req & ~req_mask) == 4'b0) begin
        r = $urandom_range(0, 3);
        req[r] = 1'b1;
        req_mask[r] = 1'b0;
      end
      r = $urandom_range(0, 7);
      if (r == 0) do_frame(0, 4'b0);
      else if (r == 1) do_frame(TO, 4'b0);
      else if (r == 2) do_frame($urandom_range(1, 15), 4'($urandom));
      else do_frame(11, 4'b0);
    end
    req = '0; req_mask = '0;

    // Counter wrap.
    @(negedge clock);
    force dut.frame_count = 16'hFFFF;
    #1 release dut.frame_count;
    model_fc = 16'hFFFF;
    check("fc_preload", frame_count, 16'hFFFF);
    req = 4'b0001;
    do_frame(11, 4'b0);
    check("fc_wrap", frame_count, 16'h0000);
    req = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
